// File: rtl/ysyx_22041461_idu.sv
// NPC instruction-decode stage: RV32I/RV64I subset decoder with one output
// register, valid/ready handshake, halt/trap FSM and a forwarded-op counter.
module ysyx_22041461_idu #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [3:0]       alu_op,
  output logic [1:0]       alu_src,
  output logic [2:0]       wb_sel,
  output logic [1:0]       mem_op,
  output logic [1:0]       mem_size,
  output logic [1:0]       br_op,
  output logic             halt,
  output logic             trap,
  output logic [CNT_W-1:0] dec_cnt
);

  localparam logic RV64 = (XLEN == 64);

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_SLL  = 4'd3;
  localparam logic [3:0] ALU_ADDW = 4'd4;
  localparam logic [3:0] ALU_SUBW = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_ACLR = 4'd7;

  localparam logic [1:0] SRC_RR = 2'd0;
  localparam logic [1:0] SRC_RI = 2'd1;
  localparam logic [1:0] SRC_PI = 2'd2;

  localparam logic [2:0] WB_NONE = 3'd0;
  localparam logic [2:0] WB_ALU  = 3'd1;
  localparam logic [2:0] WB_SNPC = 3'd2;
  localparam logic [2:0] WB_IMM  = 3'd3;
  localparam logic [2:0] WB_MEM  = 3'd4;

  localparam logic [1:0] MEM_LD = 2'd1;
  localparam logic [1:0] MEM_ST = 2'd2;

  localparam logic [1:0] BR_EQ  = 2'd1;
  localparam logic [1:0] BR_NE  = 2'd2;
  localparam logic [1:0] BR_JMP = 2'd3;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;

  assign op = in_inst[6:0];
  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];

  logic signed [11:0] raw_i;
  logic signed [11:0] raw_s;
  logic signed [12:0] raw_b;
  logic signed [31:0] raw_u;
  logic signed [20:0] raw_j;

  assign raw_i = in_inst[31:20];
  assign raw_s = {in_inst[31:25], in_inst[11:7]};
  assign raw_b = {in_inst[31], in_inst[7],
                  in_inst[30:25], in_inst[11:8], 1'b0};
  assign raw_u = {in_inst[31:12], 12'h000};
  assign raw_j = {in_inst[31], in_inst[19:12],
                  in_inst[20], in_inst[30:21], 1'b0};

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign imm_i = XLEN'(raw_i);
  assign imm_s = XLEN'(raw_s);
  assign imm_b = XLEN'(raw_b);
  assign imm_u = XLEN'(raw_u);
  assign imm_j = XLEN'(raw_j);

  logic wide_ok;
  logic f7_as;
  logic is_lui;
  logic is_auipc;
  logic is_jal;
  logic is_jalr;
  logic is_br;
  logic is_ld;
  logic is_st;
  logic is_addi;
  logic is_slli;
  logic is_sltiu;
  logic is_rr;
  logic is_rrw;
  logic is_ebrk;
  logic legal;

  // f3=011 selects the doubleword form of loads/stores, RV64 only
  assign wide_ok  = (f3 == 3'b010) || (RV64 && f3 == 3'b011);
  assign f7_as    = (f7 == 7'b000_0000) || (f7 == 7'b010_0000);

  assign is_lui   = op == 7'b011_0111;
  assign is_auipc = op == 7'b001_0111;
  assign is_jal   = op == 7'b110_1111;
  assign is_jalr  = op == 7'b110_0111 && f3 == 3'b000;
  assign is_br    = op == 7'b110_0011 && f3[2:1] == 2'b00;
  assign is_ld    = op == 7'b000_0011 && wide_ok;
  assign is_st    = op == 7'b010_0011 && wide_ok;
  assign is_addi  = op == 7'b001_0011 && f3 == 3'b000;
  assign is_slli  = op == 7'b001_0011 && f3 == 3'b001
                 && in_inst[31:26] == 6'd0
                 && (RV64 || !in_inst[25]);
  assign is_sltiu = op == 7'b001_0011 && f3 == 3'b011;
  assign is_rr    = op == 7'b011_0011 && f3 == 3'b000 && f7_as;
  assign is_rrw   = RV64 && op == 7'b011_1011
                 && f3 == 3'b000 && f7_as;
  assign is_ebrk  = in_inst == EBREAK;

  assign legal = is_lui | is_auipc | is_jal | is_jalr
               | is_br | is_ld | is_st | is_addi
               | is_slli | is_sltiu | is_rr | is_rrw;

  logic [3:0]      d_alu;
  logic [1:0]      d_src;
  logic [2:0]      d_wb;
  logic [1:0]      d_mem;
  logic [1:0]      d_sz;
  logic [1:0]      d_br;
  logic [XLEN-1:0] d_imm;

  always_comb begin
    d_alu = ALU_NONE;
    d_src = SRC_RR;
    d_wb  = WB_NONE;
    d_mem = 2'd0;
    d_sz  = 2'd0;
    d_br  = 2'd0;
    d_imm = '0;
    unique case (1'b1)
      is_lui: begin
        d_wb  = WB_IMM;
        d_imm = imm_u;
      end
      is_auipc: begin
        d_alu = ALU_ADD;
        d_src = SRC_PI;
        d_wb  = WB_ALU;
        d_imm = imm_u;
      end
      is_jal: begin
        d_alu = ALU_ADD;
        d_src = SRC_PI;
        d_wb  = WB_SNPC;
        d_br  = BR_JMP;
        d_imm = imm_j;
      end
      is_jalr: begin
        d_alu = ALU_ACLR;
        d_src = SRC_RI;
        d_wb  = WB_SNPC;
        d_br  = BR_JMP;
        d_imm = imm_i;
      end
      is_br: begin
        d_alu = ALU_ADD;
        d_src = SRC_PI;
        d_br  = f3[0] ? BR_NE : BR_EQ;
        d_imm = imm_b;
      end
      is_ld: begin
        d_alu = ALU_ADD;
        d_src = SRC_RI;
        d_wb  = WB_MEM;
        d_mem = MEM_LD;
        d_sz  = {1'b1, f3[0]};
        d_imm = imm_i;
      end
      is_st: begin
        d_alu = ALU_ADD;
        d_src = SRC_RI;
        d_mem = MEM_ST;
        d_sz  = {1'b1, f3[0]};
        d_imm = imm_s;
      end
      is_addi: begin
        d_alu = ALU_ADD;
        d_src = SRC_RI;
        d_wb  = WB_ALU;
        d_imm = imm_i;
      end
      is_slli: begin
        d_alu = ALU_SLL;
        d_src = SRC_RI;
        d_wb  = WB_ALU;
        d_imm = imm_i;
      end
      is_sltiu: begin
        d_alu = ALU_SLTU;
        d_src = SRC_RI;
        d_wb  = WB_ALU;
        d_imm = imm_i;
      end
      is_rr: begin
        d_alu = f7[5] ? ALU_SUB : ALU_ADD;
        d_wb  = WB_ALU;
      end
      is_rrw: begin
        d_alu = f7[5] ? ALU_SUBW : ALU_ADDW;
        d_wb  = WB_ALU;
      end
      default: begin
      end
    endcase
  end

  logic acc;
  logic fwd;

  assign acc = in_valid && in_ready;
  assign fwd = acc && legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // ebreak and illegal words are consumed but never forwarded
  always_comb begin
    state_nx = state;
    if (acc && is_ebrk) begin
      state_nx = HALT;
    end else if (acc && !legal) begin
      state_nx = TRAP;
    end
  end

  always_comb begin
    in_ready = (state == RUN) && !flush
            && (!out_valid || out_ready);
    halt     = (state == HALT);
    trap     = (state == TRAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      imm       <= '0;
      alu_op    <= '0;
      alu_src   <= '0;
      wb_sel    <= '0;
      mem_op    <= '0;
      mem_size  <= '0;
      br_op     <= '0;
    end else if (fwd) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      rs1       <= in_inst[19:15];
      rs2       <= in_inst[24:20];
      rd        <= in_inst[11:7];
      imm       <= d_imm;
      alu_op    <= d_alu;
      alu_src   <= d_src;
      wb_sel    <= d_wb;
      mem_op    <= d_mem;
      mem_size  <= d_sz;
      br_op     <= d_br;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt <= '0;
    end else if (fwd && dec_cnt != {CNT_W{1'b1}}) begin
      dec_cnt <= dec_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22041461_idu.sv
// Bench for ysyx_22041461_idu: directed steps plus random traffic on an
// RV64 (CNT_W=2) and an RV32 instance, checked against a pattern-table model.
module tb_ysyx_22041461_idu;

  typedef logic [157:0] bun_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [3:0]  alu;
    logic [1:0]  src;
    logic [2:0]  wb;
    logic [1:0]  mem;
    logic [1:0]  sz;
    logic [1:0]  br;
    int          it;
    int          only;
  } pat_t;

  typedef struct packed {
    logic legal;
    logic ebk;
    bun_t b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;

  logic        a_in_ready, a_out_valid, a_halt, a_trap;
  logic [63:0] a_out_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [3:0]  a_alu;
  logic [2:0]  a_wb;
  logic [1:0]  a_src, a_mem, a_sz, a_br;
  logic [1:0]  a_cnt;

  logic        b_in_ready, b_out_valid, b_halt, b_trap;
  logic [31:0] b_out_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [3:0]  b_alu;
  logic [2:0]  b_wb;
  logic [1:0]  b_src, b_mem, b_sz, b_br;
  logic [31:0] b_cnt;

  always #5 clk = ~clk;

  ysyx_22041461_idu #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_out_pc),
    .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd),
    .imm(a_imm), .alu_op(a_alu), .alu_src(a_src),
    .wb_sel(a_wb), .mem_op(a_mem), .mem_size(a_sz),
    .br_op(a_br), .halt(a_halt), .trap(a_trap),
    .dec_cnt(a_cnt)
  );

  ysyx_22041461_idu #(.XLEN(32), .CNT_W(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_out_pc),
    .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
    .imm(b_imm), .alu_op(b_alu), .alu_src(b_src),
    .wb_sel(b_wb), .mem_op(b_mem), .mem_size(b_sz),
    .br_op(b_br), .halt(b_halt), .trap(b_trap),
    .dec_cnt(b_cnt)
  );

  bun_t a_bun, b_bun;
  assign a_bun = {a_out_pc, a_rs1, a_rs2, a_rd, a_imm,
                  a_alu, a_src, a_wb, a_mem, a_sz, a_br};
  assign b_bun = {32'h0, b_out_pc, b_rs1, b_rs2, b_rd,
                  32'h0, b_imm,
                  b_alu, b_src, b_wb, b_mem, b_sz, b_br};

  int npass = 0;
  int ntot  = 0;

  pat_t   pats[$];
  bit     mv[2];
  int     mst[2];
  longint mcnt[2];
  longint mmax[2];
  bun_t   mb[2];

  task automatic chk(string tag, bun_t got, bun_t exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic void add(logic [31:0] mask, logic [31:0] match,
                              logic [3:0] alu, logic [1:0] src,
                              logic [2:0] wb, logic [1:0] mem,
                              logic [1:0] sz, logic [1:0] br,
                              int it, int only);
    pat_t p;
    p.mask = mask; p.match = match; p.alu = alu; p.src = src;
    p.wb = wb; p.mem = mem; p.sz = sz; p.br = br;
    p.it = it; p.only = only;
    pats.push_back(p);
  endfunction

  // it: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J ; only: 0 both, 1 RV64, 2 RV32
  function automatic logic [63:0] immv(logic [31:0] x, int it);
    longint s = longint'($signed(x));
    logic [63:0] sg = s >>> 31;
    case (it)
      1: return s >>> 20;
      2: return ((s >>> 25) << 5) | 64'(x[11:7]);
      3: return (sg << 12) | (64'(x[7]) << 11)
              | (64'(x[30:25]) << 5) | (64'(x[11:8]) << 1);
      4: return s & ~64'hfff;
      5: return (sg << 20) | (64'(x[19:12]) << 12)
              | (64'(x[20]) << 11) | (64'(x[30:21]) << 1);
      default: return 64'h0;
    endcase
  endfunction

  function automatic exp_t decode(int d, logic [31:0] x, logic [63:0] pc);
    exp_t e;
    logic [63:0] iv;
    logic [63:0] pv;
    e.legal = 1'b0;
    e.ebk = (x == 32'h0010_0073);
    e.b = '0;
    foreach (pats[i]) begin
      if (!e.legal && (x & pats[i].mask) == pats[i].match &&
          (pats[i].only == 0 || (pats[i].only == 1 && d == 0) ||
           (pats[i].only == 2 && d == 1))) begin
        e.legal = 1'b1;
        iv = immv(x, pats[i].it);
        pv = pc;
        if (d == 1) begin
          iv = {32'h0, iv[31:0]};
          pv = {32'h0, pc[31:0]};
        end
        e.b = {pv, x[19:15], x[24:20], x[11:7], iv,
               pats[i].alu, pats[i].src, pats[i].wb,
               pats[i].mem, pats[i].sz, pats[i].br};
      end
    end
    return e;
  endfunction

  function automatic bit rdy(int d);
    return mst[d] == 0 && !flush && (!mv[d] || out_ready);
  endfunction

  task automatic model_update();
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      bit acc;
      if (rst) begin
        mv[d] = 0; mst[d] = 0; mcnt[d] = 0; mb[d] = '0;
      end else begin
        acc = in_valid && rdy(d);
        e = decode(d, in_inst, in_pc);
        if (acc && e.ebk) mst[d] = 1;
        else if (acc && !e.legal) mst[d] = 2;
        if (acc && e.legal) begin
          mv[d] = 1;
          mb[d] = e.b;
          if (mcnt[d] < mmax[d]) mcnt[d]++;
        end else if (flush || out_ready) begin
          mv[d] = 0;
        end
      end
    end
  endtask

  task automatic check_outs();
    chk("a_valid", a_out_valid, mv[0]);
    chk("a_hlt_trp", {a_halt, a_trap}, {mst[0] == 1, mst[0] == 2});
    chk("a_cnt", a_cnt, mcnt[0]);
    chk("a_bundle", a_bun, mb[0]);
    chk("b_valid", b_out_valid, mv[1]);
    chk("b_hlt_trp", {b_halt, b_trap}, {mst[1] == 1, mst[1] == 2});
    chk("b_cnt", b_cnt, mcnt[1]);
    chk("b_bundle", b_bun, mb[1]);
  endtask

  task automatic step();
    #1;
    chk("a_in_ready", a_in_ready, rdy(0));
    chk("b_in_ready", b_in_ready, rdy(1));
    model_update();
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_flags", {a_halt, a_trap}, 0);
    chk("rst_a_bundle", a_bun, 0);
    chk("rst_b_bundle", b_bun, 0);
    model_update();
    check_outs();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int cexp[5] = '{1, 2, 3, 3, 3};
    int r;
    mmax[0] = 3;
    mmax[1] = 64'hffff_ffff;
    add(32'h7f, 32'h37, 0, 0, 3, 0, 0, 0, 4, 0);
    add(32'h7f, 32'h17, 1, 2, 1, 0, 0, 0, 4, 0);
    add(32'h7f, 32'h6f, 1, 2, 2, 0, 0, 3, 5, 0);
    add(32'h707f, 32'h67, 7, 1, 2, 0, 0, 3, 1, 0);
    add(32'h707f, 32'h63, 1, 2, 0, 0, 0, 1, 3, 0);
    add(32'h707f, 32'h1063, 1, 2, 0, 0, 0, 2, 3, 0);
    add(32'h707f, 32'h2003, 1, 1, 4, 1, 2, 0, 1, 0);
    add(32'h707f, 32'h3003, 1, 1, 4, 1, 3, 0, 1, 1);
    add(32'h707f, 32'h2023, 1, 1, 0, 2, 2, 0, 2, 0);
    add(32'h707f, 32'h3023, 1, 1, 0, 2, 3, 0, 2, 1);
    add(32'h707f, 32'h13, 1, 1, 1, 0, 0, 0, 1, 0);
    add(32'hfc00707f, 32'h1013, 3, 1, 1, 0, 0, 0, 1, 1);
    add(32'hfe00707f, 32'h1013, 3, 1, 1, 0, 0, 0, 1, 2);
    add(32'h707f, 32'h3013, 6, 1, 1, 0, 0, 0, 1, 0);
    add(32'hfe00707f, 32'h33, 1, 0, 1, 0, 0, 0, 0, 0);
    add(32'hfe00707f, 32'h40000033, 2, 0, 1, 0, 0, 0, 0, 0);
    add(32'hfe00707f, 32'h3b, 4, 0, 1, 0, 0, 0, 0, 1);
    add(32'hfe00707f, 32'h4000003b, 5, 0, 1, 0, 0, 0, 0, 1);

    do_reset();

    in_valid = 1; out_ready = 1;
    in_inst = 32'hfff0_0093; in_pc = 64'h8000_0000;
    step();
    chk("addi_valid", a_out_valid, 1);
    chk("addi_rd", a_rd, 1);
    chk("addi_imm", a_imm, 64'hffff_ffff_ffff_ffff);
    chk("addi_ctl", {a_alu, a_src, a_wb}, {4'd1, 2'd1, 3'd1});
    chk("addi_pc", a_out_pc, 64'h8000_0000);
    chk("addi_cnt", a_cnt, 1);
    chk("addi_imm32", b_imm, 32'hffff_ffff);

    in_inst = 32'h0011_3423; in_pc = 64'h8000_0004;
    step();
    chk("sd_mem", {a_mem, a_sz, a_imm}, {2'd2, 2'd3, 64'd8});
    chk("sd_trap32", b_trap, 1);

    out_ready = 0; in_inst = 32'hfff0_0093; in_pc = 64'h8000_0008;
    step();
    step();
    chk("bp_ready", a_in_ready, 0);
    chk("bp_hold", {a_out_valid, a_mem, a_sz, a_imm},
        {1'b1, 2'd2, 2'd3, 64'd8});
    out_ready = 1;
    step();
    chk("bp_next", {a_mem, a_imm}, {2'd0, 64'hffff_ffff_ffff_ffff});
    chk("bp_cnt", a_cnt, 3);

    flush = 1; out_ready = 0; in_inst = 32'h0080_006f;
    #1;
    chk("fl_ready", a_in_ready, 0);
    step();
    chk("fl_valid", a_out_valid, 0);
    chk("fl_cnt", a_cnt, 3);
    flush = 0; out_ready = 1;

    do_reset();
    in_inst = 32'hfff0_0093;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("cnt_sat", a_cnt, cexp[i]);
    end
    do_reset();

    in_inst = 32'h0010_0073;
    step();
    chk("ebrk_halt", {a_halt, a_out_valid, a_cnt}, {1'b1, 1'b0, 2'd0});
    in_inst = 32'hfff0_0093;
    step();
    chk("halt_ready", a_in_ready, 0);
    do_reset();

    in_inst = 32'h0;
    step();
    chk("zero_trap", {a_trap, b_trap}, 2'b11);
    do_reset();
    in_inst = 32'h0010_80bb;
    step();
    chk("addw_trap32", b_trap, 1);
    chk("addw_ok64", {a_trap, a_out_valid, a_alu}, {1'b0, 1'b1, 4'd4});
    do_reset();

    for (int n = 0; n < 700; n++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 16) == 0;
      in_pc = {$urandom, $urandom};
      r = $urandom % 40;
      if (r == 0) in_inst = 32'h0010_0073;
      else if (r < 3) in_inst = $urandom;
      else begin
        pat_t p = pats[$urandom_range(0, pats.size() - 1)];
        in_inst = p.match | ($urandom & ~p.mask);
      end
      step();
      if ((mst[0] != 0 || mst[1] != 0) && ($urandom % 4) == 0)
        do_reset();
      else if (($urandom % 100) == 0)
        do_reset();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
